// File: rtl/cpu_sequencer.sv
// cpu_sequencer: instruction-cycle controller for the 8-bit CPU.
// Steps an 8-phase fetch/execute sequence (INST_ADDR..STORE) and decodes
// the datapath strobes from the current phase, the IR opcode and the ALU
// zero flag. An HLT seen in OP_ADDR parks the sequencer in HALTED.
// Optional build macro CPU_SEQ_RESUME_EN adds a `resume` input that lets
// HALTED return to INST_ADDR; without it HALTED exits only through rst.
module cpu_sequencer #(
    parameter int unsigned PHASE_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2:0]         opcode,
    input  logic               skz_zero,
`ifdef CPU_SEQ_RESUME_EN
    input  logic               resume,
`endif
    output logic               sel,
    output logic               rd,
    output logic               ld_ir,
    output logic               inc_pc,
    output logic               ld_pc,
    output logic               ld_ac,
    output logic               wr,
    output logic               data_e,
    output logic               halt,
    output logic [PHASE_W-1:0] phase
);

    typedef enum logic [3:0] {
        S_INST_ADDR  = 4'd0,
        S_INST_FETCH = 4'd1,
        S_INST_LOAD  = 4'd2,
        S_IDLE       = 4'd3,
        S_OP_ADDR    = 4'd4,
        S_OP_FETCH   = 4'd5,
        S_ALU_OP     = 4'd6,
        S_STORE      = 4'd7,
        S_HALTED     = 4'd8
    } state_e;

    typedef enum logic [2:0] {
        OP_HLT = 3'b000,
        OP_SKZ = 3'b001,
        OP_ADD = 3'b010,
        OP_AND = 3'b011,
        OP_XOR = 3'b100,
        OP_LDA = 3'b101,
        OP_STO = 3'b110,
        OP_JMP = 3'b111
    } opcode_e;

    state_e               state_q, state_d;
    logic [PHASE_W-1:0]   phase_q, phase_d;

    logic is_hlt, is_skz, is_sto, is_jmp, is_aluop;

    assign is_hlt   = (opcode == OP_HLT);
    assign is_skz   = (opcode == OP_SKZ);
    assign is_sto   = (opcode == OP_STO);
    assign is_jmp   = (opcode == OP_JMP);
    assign is_aluop = (opcode == OP_ADD) | (opcode == OP_AND) |
                      (opcode == OP_XOR) | (opcode == OP_LDA);

    // Next-state selection: one phase per clock, HLT diverts OP_ADDR to HALTED.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INST_ADDR:  state_d = S_INST_FETCH;
            S_INST_FETCH: state_d = S_INST_LOAD;
            S_INST_LOAD:  state_d = S_IDLE;
            S_IDLE:       state_d = S_OP_ADDR;
            S_OP_ADDR:    state_d = is_hlt ? S_HALTED : S_OP_FETCH;
            S_OP_FETCH:   state_d = S_ALU_OP;
            S_ALU_OP:     state_d = S_STORE;
            S_STORE:      state_d = S_INST_ADDR;
            S_HALTED: begin
`ifdef CPU_SEQ_RESUME_EN
                state_d = resume ? S_INST_ADDR : S_HALTED;
`else
                state_d = S_HALTED;
`endif
            end
            default:      state_d = S_INST_ADDR;
        endcase
    end

    // Debug phase index follows the next state; HALTED reports phase 7.
    always_comb begin
        if (state_d == S_HALTED) begin
            phase_d = '1;
        end else begin
            phase_d = PHASE_W'(state_d);
        end
    end

    // State and phase registers; phase is registered so no input reaches it combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_INST_ADDR;
            phase_q <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;

    // Strobe decode from the state register plus opcode/skz_zero.
    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        ld_ir  = 1'b0;
        inc_pc = 1'b0;
        ld_pc  = 1'b0;
        ld_ac  = 1'b0;
        wr     = 1'b0;
        data_e = 1'b0;
        halt   = 1'b0;
        case (state_q)
            S_INST_ADDR: begin
                sel = 1'b1;
            end
            S_INST_FETCH: begin
                sel = 1'b1;
                rd  = 1'b1;
            end
            S_INST_LOAD, S_IDLE: begin
                sel   = 1'b1;
                rd    = 1'b1;
                ld_ir = 1'b1;
            end
            S_OP_ADDR: begin
                inc_pc = 1'b1;
                halt   = is_hlt;
            end
            S_OP_FETCH: begin
                rd = is_aluop;
            end
            S_ALU_OP: begin
                rd     = is_aluop;
                ld_ac  = is_aluop;
                inc_pc = is_skz & skz_zero;
                ld_pc  = is_jmp;
                data_e = is_sto;
            end
            S_STORE: begin
                rd     = is_aluop;
                ld_ac  = is_aluop;
                inc_pc = is_jmp;
                ld_pc  = is_jmp;
                wr     = is_sto;
                data_e = is_sto;
            end
            S_HALTED: begin
                halt = 1'b1;
            end
            default: begin
                sel = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: per-phase strobe tables per opcode.
module tb_cpu_sequencer;

    logic       clk;
    logic       rst;
    logic [2:0] opcode;
    logic       skz_zero;
`ifdef CPU_SEQ_RESUME_EN
    logic       resume;
`endif
    logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;
    logic [2:0] phase;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Strobe vector order: {sel,rd,ld_ir,inc_pc,ld_pc,ld_ac,wr,data_e,halt}
    logic [8:0] ev [8];

    localparam logic [2:0] HLT = 3'b000, SKZ = 3'b001, ADD = 3'b010, AND_ = 3'b011,
                           XOR_ = 3'b100, LDA = 3'b101, STO = 3'b110, JMP = 3'b111;

    cpu_sequencer #(.PHASE_W(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .opcode   (opcode),
        .skz_zero (skz_zero),
`ifdef CPU_SEQ_RESUME_EN
        .resume   (resume),
`endif
        .sel      (sel),
        .rd       (rd),
        .ld_ir    (ld_ir),
        .inc_pc   (inc_pc),
        .ld_pc    (ld_pc),
        .ld_ac    (ld_ac),
        .wr       (wr),
        .data_e   (data_e),
        .halt     (halt),
        .phase    (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [8:0] exp_v, input logic [2:0] exp_ph);
        logic [8:0] obs;
        obs = {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt};
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s strobes observed %b expected %b", tag, obs, exp_v);
        end
        checks++;
        assert (phase === exp_ph) else begin
            errors++;
            $error("FAIL %s phase observed %0d expected %0d", tag, phase, exp_ph);
        end
    endtask

    task automatic set_tail(input logic [8:0] p4, input logic [8:0] p5,
                            input logic [8:0] p6, input logic [8:0] p7);
        ev[0] = 9'b100000000;
        ev[1] = 9'b110000000;
        ev[2] = 9'b111000000;
        ev[3] = 9'b111000000;
        ev[4] = p4;
        ev[5] = p5;
        ev[6] = p6;
        ev[7] = p7;
    endtask

    // Checks phases 0..nph-1 of one instruction, stepping after each.
    task automatic run_instr(input string name, input logic [2:0] op, input logic z,
                             input int unsigned nph);
        opcode   = op;
        skz_zero = z;
        #1;
        for (int p = 0; p < int'(nph); p++) begin
            check($sformatf("%s_p%0d", name, p), ev[p], 3'(p));
            step();
        end
    endtask

    initial begin
        rst      = 1'b1;
        opcode   = ADD;
        skz_zero = 1'b0;
`ifdef CPU_SEQ_RESUME_EN
        resume   = 1'b0;
`endif
        step();
        step();
        check("reset", 9'b100000000, 3'd0);
        rst = 1'b0;
        #1;

        set_tail(9'b000100000, 9'b010000000, 9'b010001000, 9'b010001000);
        run_instr("add", ADD, 1'b0, 8);
        check("add_wrap", 9'b100000000, 3'd0);
        run_instr("lda", LDA, 1'b1, 8);
        run_instr("and", AND_, 1'b0, 8);
        run_instr("xor", XOR_, 1'b1, 8);

        set_tail(9'b000100000, 9'b000000000, 9'b000000010, 9'b000000110);
        run_instr("sto", STO, 1'b0, 8);

        set_tail(9'b000100000, 9'b000000000, 9'b000100000, 9'b000000000);
        run_instr("skz1", SKZ, 1'b1, 8);
        set_tail(9'b000100000, 9'b000000000, 9'b000000000, 9'b000000000);
        run_instr("skz0", SKZ, 1'b0, 8);

        set_tail(9'b000100000, 9'b000000000, 9'b000010000, 9'b000110000);
        run_instr("jmp", JMP, 1'b0, 8);

        // Asynchronous reset while wr is asserted in STORE.
        set_tail(9'b000100000, 9'b000000000, 9'b000000010, 9'b000000110);
        run_instr("sto_mid", STO, 1'b0, 8 - 1);
        check("sto_mid_p7", 9'b000000110, 3'd7);
        rst = 1'b1;
        #1;
        check("async_rst", 9'b100000000, 3'd0);
        rst = 1'b0;
        #1;
        step();
        check("after_rst", 9'b110000000, 3'd1);
        for (int i = 0; i < 7; i++) step();

        set_tail(9'b000100001, 9'b000000000, 9'b000000000, 9'b000000000);
        run_instr("hlt", HLT, 1'b0, 5);
        opcode = ADD;
        #1;
        for (int i = 0; i < 20; i++) begin
            check($sformatf("halted_%0d", i), 9'b000000001, 3'd7);
            step();
        end
        rst = 1'b1;
        #1;
        check("halt_rst", 9'b100000000, 3'd0);
        step();
        rst = 1'b0;
        #1;
        step();
        check("halt_rst_run", 9'b110000000, 3'd1);

`ifdef CPU_SEQ_RESUME_EN
        for (int i = 0; i < 7; i++) step();
        set_tail(9'b000100001, 9'b000000000, 9'b000000000, 9'b000000000);
        run_instr("hlt2", HLT, 1'b0, 5);
        check("halted2", 9'b000000001, 3'd7);
        resume = 1'b1;
        step();
        resume = 1'b0;
        #1;
        check("resume", 9'b100000000, 3'd0);
        step();
        check("resume_run", 9'b110000000, 3'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
